// File: rtl/data_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module : data_mem_responder_if
// Brief  : CEN/WEN/OEN data-memory port between the processor and the memory.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_mem_responder_if;
  logic        CEN;
  logic        WEN;
  logic        OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;

  modport master (
    output CEN, WEN, OEN, A, Data2Mem,
    input  ReadDataMem
  );

  modport slave (
    input  CEN, WEN, OEN, A, Data2Mem,
    output ReadDataMem
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
//------------------------------------------------------------------------------
// Module : data_mem_responder
// Brief  : Word-addressed data memory with combinational reads, clocked writes,
//          saturating access counters and a sticky out-of-range error flag.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  data_mem_responder_if.slave    bus,
  input  wire logic              err_clr,
  output logic                   err,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt
);

  localparam int         c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] c_depth = 8'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic             r_err;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;

  logic             w_in_range;
  logic             w_rd_en;
  logic             w_wr_en;
  logic             w_bad;
  logic [c_aw-1:0]  w_idx;

  // Compare in 8 bits so DEPTH=128 is representable next to the 7-bit address.
  assign w_in_range = ({1'b0, bus.A} < c_depth);
  assign w_idx      = bus.A[c_aw-1:0];
  assign w_rd_en    = !bus.CEN &&  bus.WEN && !bus.OEN && w_in_range;
  assign w_wr_en    = !bus.CEN && !bus.WEN && w_in_range;
  assign w_bad      = !bus.CEN && !w_in_range;

  assign bus.ReadDataMem = w_rd_en ? r_mem[w_idx] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      r_mem[w_idx] <= bus.Data2Mem;
    end
  end

  // A bad access takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_en && (r_rd_cnt != {CNT_W{1'b1}})) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_wr_en && (r_wr_cnt != {CNT_W{1'b1}})) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  assign err    = r_err;
  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//------------------------------------------------------------------------------
// Module : tb_data_mem_responder
// Brief  : Directed self-checking bench for a default build and a DEPTH=64/CNT_W=4 build.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        err_clr_m;
  logic        err_clr_s;
  logic        err_m;
  logic        err_s;
  logic [15:0] rd_cnt_m;
  logic [15:0] wr_cnt_m;
  logic [3:0]  rd_cnt_s;
  logic [3:0]  wr_cnt_s;

  int n_cmp;
  int n_mis;

  data_mem_responder_if m_bus ();
  data_mem_responder_if s_bus ();

  data_mem_responder u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (m_bus.slave),
    .err_clr (err_clr_m),
    .err     (err_m),
    .rd_cnt  (rd_cnt_m),
    .wr_cnt  (wr_cnt_m)
  );

  data_mem_responder #(.DEPTH(64), .CNT_W(4)) u_dut_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (s_bus.slave),
    .err_clr (err_clr_s),
    .err     (err_s),
    .rd_cnt  (rd_cnt_s),
    .wr_cnt  (wr_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_drive(input logic cen, input logic wen, input logic oen,
                         input logic [6:0] a, input logic [31:0] d);
    m_bus.CEN = cen; m_bus.WEN = wen; m_bus.OEN = oen; m_bus.A = a; m_bus.Data2Mem = d;
  endtask

  task automatic s_drive(input logic cen, input logic wen, input logic oen,
                         input logic [6:0] a, input logic [31:0] d);
    s_bus.CEN = cen; s_bus.WEN = wen; s_bus.OEN = oen; s_bus.A = a; s_bus.Data2Mem = d;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    err_clr_m = 1'b0;
    err_clr_s = 1'b0;
    m_drive(1'b0, 1'b1, 1'b0, 7'd0, 32'd0);
    s_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    #12;
    check_val("rst_rdata", m_bus.ReadDataMem, 32'd0);
    check_val("rst_err",   {31'd0, err_m},    32'd0);
    check_val("rst_rdcnt", {16'd0, rd_cnt_m}, 32'd0);
    check_val("rst_wrcnt", {16'd0, wr_cnt_m}, 32'd0);
    m_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Whole array reads back zero after reset
    for (int a = 0; a < 128; a++) begin
      m_drive(1'b0, 1'b1, 1'b0, 7'(a), 32'd0);
      #2;
      check_val($sformatf("init_rd_%0d", a), m_bus.ReadDataMem, 32'd0);
      tick();
    end
    m_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    check_val("rdcnt_128", {16'd0, rd_cnt_m}, 32'd128);

    // Write then read-after-write
    m_drive(1'b0, 1'b0, 1'b0, 7'd5, 32'hDEADBEEF);
    #2;
    check_val("wr_rdata_zero", m_bus.ReadDataMem, 32'd0);
    tick();
    check_val("wrcnt_1", {16'd0, wr_cnt_m}, 32'd1);
    m_drive(1'b0, 1'b1, 1'b0, 7'd5, 32'd0);
    #1;
    check_val("raw_a5", m_bus.ReadDataMem, 32'hDEADBEEF);
    tick();
    check_val("rdcnt_129", {16'd0, rd_cnt_m}, 32'd129);

    // OEN gating and CEN-suppressed write
    m_drive(1'b0, 1'b1, 1'b1, 7'd5, 32'd0);
    #2;
    check_val("oen_gate", m_bus.ReadDataMem, 32'd0);
    tick();
    check_val("oen_rdcnt", {16'd0, rd_cnt_m}, 32'd129);
    m_drive(1'b1, 1'b0, 1'b0, 7'd5, 32'h0BADF00D);
    #2;
    check_val("cen_gate", m_bus.ReadDataMem, 32'd0);
    tick();
    check_val("cen_wrcnt", {16'd0, wr_cnt_m}, 32'd1);
    m_drive(1'b0, 1'b1, 1'b0, 7'd5, 32'd0);
    #2;
    check_val("a5_kept", m_bus.ReadDataMem, 32'hDEADBEEF);
    tick();

    // Top address, write with OEN high still commits
    m_drive(1'b0, 1'b0, 1'b1, 7'd127, 32'hA5A5_5A5A);
    tick();
    m_drive(1'b0, 1'b1, 1'b0, 7'd127, 32'd0);
    #2;
    check_val("a127", m_bus.ReadDataMem, 32'hA5A5_5A5A);
    tick();
    m_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    check_val("wrcnt_2", {16'd0, wr_cnt_m}, 32'd2);
    check_val("err_m_clean", {31'd0, err_m}, 32'd0);

    // Small build: out-of-range handling
    s_drive(1'b0, 1'b0, 1'b0, 7'd63, 32'h0000_0055);
    tick();
    check_val("s_wrcnt_1", {28'd0, wr_cnt_s}, 32'd1);
    s_drive(1'b0, 1'b0, 1'b0, 7'd70, 32'hFFFF_FFFF);
    #2;
    check_val("s_bad_rdata", s_bus.ReadDataMem, 32'd0);
    tick();
    check_val("s_err_set", {31'd0, err_s}, 32'd1);
    check_val("s_bad_wrcnt", {28'd0, wr_cnt_s}, 32'd1);
    s_drive(1'b0, 1'b1, 1'b0, 7'd6, 32'd0);
    #2;
    check_val("s_alias_a6", s_bus.ReadDataMem, 32'd0);
    tick();
    s_drive(1'b0, 1'b1, 1'b0, 7'd63, 32'd0);
    #2;
    check_val("s_a63", s_bus.ReadDataMem, 32'h0000_0055);
    tick();
    s_drive(1'b0, 1'b1, 1'b0, 7'd70, 32'd0);
    err_clr_s = 1'b1;
    #2;
    check_val("s_bad_rd", s_bus.ReadDataMem, 32'd0);
    tick();
    check_val("s_err_bad_wins", {31'd0, err_s}, 32'd1);
    check_val("s_rdcnt_2", {28'd0, rd_cnt_s}, 32'd2);
    s_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    tick();
    check_val("s_err_clr", {31'd0, err_s}, 32'd0);
    err_clr_s = 1'b0;
    tick();
    check_val("s_err_hold0", {31'd0, err_s}, 32'd0);

    // Small build: rd_cnt saturation
    s_drive(1'b0, 1'b1, 1'b0, 7'd0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val($sformatf("s_sat_%0d", i), {28'd0, rd_cnt_s},
                (i + 3 > 15) ? 32'd15 : 32'(i + 3));
    end
    s_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);

    // Mid-cycle reset discards the pending write
    m_drive(1'b0, 1'b0, 1'b0, 7'd9, 32'h0000_1234);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mrst_err",   {31'd0, err_m},    32'd0);
    check_val("mrst_rdcnt", {16'd0, rd_cnt_m}, 32'd0);
    check_val("mrst_wrcnt", {16'd0, wr_cnt_m}, 32'd0);
    check_val("mrst_s_rdcnt", {28'd0, rd_cnt_s}, 32'd0);
    tick();
    m_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_drive(1'b0, 1'b1, 1'b0, 7'd9, 32'd0);
    #2;
    check_val("post_rst_a9", m_bus.ReadDataMem, 32'd0);
    tick();
    m_drive(1'b0, 1'b1, 1'b0, 7'd5, 32'd0);
    #2;
    check_val("post_rst_a5", m_bus.ReadDataMem, 32'd0);
    tick();
    m_drive(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    check_val("post_rst_rdcnt", {16'd0, rd_cnt_m}, 32'd2);
    check_val("post_rst_wrcnt", {16'd0, wr_cnt_m}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
